variable_proposal_generator: RTL and testbench

//  Consumes the (type, index) pick from VariableChooser and builds one MCMC move proposal.

---
 rtl/variable_proposal_generator_pkg.sv | 31 +++
 rtl/variable_proposal_generator_step_lfsr.sv | 28 ++
 rtl/variable_proposal_generator.sv | 169 ++++++++++++++++
 tb/tb_variable_proposal_generator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/variable_proposal_generator_pkg.sv
// Shared constants, FSM encoding and helpers for the MCMC move-proposal stage.
package variable_proposal_generator_pkg;

   localparam int BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 4;
   localparam int BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 4;

   // Galois mask for x^8+x^6+x^5+x^4+1, right-shifting form.
   localparam logic [7:0] STEP_LFSR_TAPS = 8'hB8;

   typedef enum logic [1:0] {
      VPG_IDLE    = 2'd0,
      VPG_PROPOSE = 2'd1,
      VPG_OFFER   = 2'd2
   } vpg_state_e;

   function automatic logic [7:0] step_lfsr_next(input logic [7:0] state);
      return state[0] ? ((state >> 1) ^ STEP_LFSR_TAPS) : (state >> 1);
   endfunction

   function automatic logic index_in_range(
      input logic                                           is_boolean,
      input logic [BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX-1:0] index,
      input int                                             num_bool,
      input int                                             num_int
   );
      int index_i;
      index_i = int'(index);
      return is_boolean ? (index_i < num_bool) : (index_i < num_int);
   endfunction

endpackage

// File: rtl/variable_proposal_generator_step_lfsr.sv
// 8-bit Galois LFSR that steps only when asked; shared by stages needing cheap randomness.
module step_lfsr
   import variable_proposal_generator_pkg::*;
#(
   parameter logic [7:0] SEED = 8'h5A
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       advance,
   output logic [7:0] out_state
);

   logic [7:0] state_q;
   logic [7:0] state_d;

   always_comb begin
      state_d = state_q;
      if (advance) state_d = step_lfsr_next(state_q);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= SEED;
      else          state_q <= state_d;
   end

   assign out_state = state_q;

endmodule

// File: rtl/variable_proposal_generator.sv
// Holds boolean/integer variable assignments and turns a chooser pick into one proposal,
// committing it on accept and discarding it on reject.
module variable_proposal_generator
   import variable_proposal_generator_pkg::*;
#(
   parameter int         NUM_BOOL   = 8,
   parameter int         NUM_INT    = 4,
   parameter int         INT_WIDTH  = 8,
   parameter int         INT_MIN    = -128,
   parameter int         INT_MAX    = 127,
   parameter int         STEP_WIDTH = 2,
   parameter logic [7:0] LFSR_SEED  = 8'h5A
) (
   input  logic                                           in_clock,
   input  logic                                           in_reset,
   input  logic                                           in_choice_valid,
   input  logic                                           in_boolean_or_integer,
   input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX-1:0] in_choosen_index,
   output logic                                           out_choice_ready,
   input  logic                                           in_init_we,
   input  logic                                           in_init_is_boolean,
   input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX-1:0] in_init_index,
   input  logic [INT_WIDTH-1:0]                           in_init_value,
   output logic                                           out_proposal_valid,
   output logic                                           out_proposal_is_boolean,
   output logic [BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX-1:0] out_proposal_index,
   output logic [INT_WIDTH-1:0]                           out_old_value,
   output logic [INT_WIDTH-1:0]                           out_new_value,
   input  logic                                           in_decision_valid,
   input  logic                                           in_accept,
   output logic                                           out_index_error,
   output logic [NUM_BOOL-1:0]                            out_bool_assignment,
   output logic [1:0]                                     out_debug_state,
   output logic [7:0]                                     out_debug_lfsr
);

   localparam int IW  = BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
   localparam int BIW = (NUM_BOOL > 1) ? $clog2(NUM_BOOL) : 1;
   localparam int NIW = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
   localparam logic signed [INT_WIDTH:0] INT_MIN_EXT = (INT_WIDTH+1)'(INT_MIN);
   localparam logic signed [INT_WIDTH:0] INT_MAX_EXT = (INT_WIDTH+1)'(INT_MAX);

   vpg_state_e                  state_q;
   logic                        sel_is_bool_q;
   logic [IW-1:0]               sel_index_q;
   logic                        prop_valid_q;
   logic                        prop_is_bool_q;
   logic [IW-1:0]               prop_index_q;
   logic [INT_WIDTH-1:0]        old_q;
   logic [INT_WIDTH-1:0]        new_q;
   logic                        index_error_q;
   logic [NUM_BOOL-1:0]         bool_q;
   logic [INT_WIDTH-1:0]        int_q [NUM_INT];

   logic [7:0]                  lfsr_state;
   logic                        choice_ready;
   logic                        choice_fire;
   logic                        choice_in_range;
   logic                        init_in_range;
   logic [INT_WIDTH-1:0]        old_value_d;
   logic [INT_WIDTH-1:0]        new_value_d;
   logic signed [INT_WIDTH:0]   old_ext;
   logic signed [INT_WIDTH:0]   step_ext;
   logic signed [INT_WIDTH:0]   sum;

   // Choice handshake: a pick transfers at a rising edge where in_choice_valid and
   // out_choice_ready are both 1; ready is only offered in IDLE with no init write pending.
   assign choice_ready    = in_reset & (state_q == VPG_IDLE) & ~in_init_we;
   assign choice_fire     = in_choice_valid & choice_ready;
   assign choice_in_range = index_in_range(in_boolean_or_integer, in_choosen_index, NUM_BOOL, NUM_INT);
   assign init_in_range   = index_in_range(in_init_is_boolean, in_init_index, NUM_BOOL, NUM_INT);

   step_lfsr #(
      .SEED      (LFSR_SEED)
   ) u_step_lfsr (
      .clock     (in_clock),
      .reset_n   (in_reset),
      .advance   (choice_fire),
      .out_state (lfsr_state)
   );

   // Widen by one bit so the signed walk can overshoot before clamping.
   always_comb begin
      old_value_d = '0;
      new_value_d = '0;
      old_ext     = '0;
      step_ext    = '0;
      sum         = '0;
      if (sel_is_bool_q) begin
         old_value_d = {{(INT_WIDTH-1){1'b0}}, bool_q[sel_index_q[BIW-1:0]]};
         new_value_d = {{(INT_WIDTH-1){1'b0}}, ~bool_q[sel_index_q[BIW-1:0]]};
      end else begin
         old_value_d = int_q[sel_index_q[NIW-1:0]];
         old_ext     = $signed({old_value_d[INT_WIDTH-1], old_value_d});
         step_ext    = $signed((INT_WIDTH+1)'(lfsr_state[STEP_WIDTH-1:0]) + (INT_WIDTH+1)'(1));
         sum         = lfsr_state[7] ? (old_ext - step_ext) : (old_ext + step_ext);
         if (sum < INT_MIN_EXT)      new_value_d = INT_MIN_EXT[INT_WIDTH-1:0];
         else if (sum > INT_MAX_EXT) new_value_d = INT_MAX_EXT[INT_WIDTH-1:0];
         else                        new_value_d = sum[INT_WIDTH-1:0];
      end
   end

   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         state_q        <= VPG_IDLE;
         sel_is_bool_q  <= 1'b0;
         sel_index_q    <= '0;
         prop_valid_q   <= 1'b0;
         prop_is_bool_q <= 1'b0;
         prop_index_q   <= '0;
         old_q          <= '0;
         new_q          <= '0;
         index_error_q  <= 1'b0;
      end else begin
         index_error_q <= 1'b0;
         case (state_q)
            VPG_IDLE: begin
               if (choice_fire) begin
                  sel_is_bool_q <= in_boolean_or_integer;
                  sel_index_q   <= in_choosen_index;
                  if (choice_in_range) state_q       <= VPG_PROPOSE;
                  else                 index_error_q <= 1'b1;
               end
            end
            VPG_PROPOSE: begin
               prop_valid_q   <= 1'b1;
               prop_is_bool_q <= sel_is_bool_q;
               prop_index_q   <= sel_index_q;
               old_q          <= old_value_d;
               new_q          <= new_value_d;
               state_q        <= VPG_OFFER;
            end
            VPG_OFFER: begin
               if (in_decision_valid) begin
                  prop_valid_q <= 1'b0;
                  state_q      <= VPG_IDLE;
               end
            end
            default: state_q <= VPG_IDLE;
         endcase
      end
   end

   // Init writes and commits live in disjoint states, so they never collide.
   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         bool_q <= '0;
         for (int i = 0; i < NUM_INT; i++) int_q[i] <= '0;
      end else if ((state_q == VPG_IDLE) && in_init_we && init_in_range) begin
         if (in_init_is_boolean) bool_q[in_init_index[BIW-1:0]] <= in_init_value[0];
         else                    int_q[in_init_index[NIW-1:0]]  <= in_init_value;
      end else if ((state_q == VPG_OFFER) && in_decision_valid && in_accept) begin
         if (prop_is_bool_q) bool_q[prop_index_q[BIW-1:0]] <= new_q[0];
         else                int_q[prop_index_q[NIW-1:0]]  <= new_q;
      end
   end

   assign out_choice_ready        = choice_ready;
   assign out_proposal_valid      = prop_valid_q;
   assign out_proposal_is_boolean = prop_is_bool_q;
   assign out_proposal_index      = prop_index_q;
   assign out_old_value           = old_q;
   assign out_new_value           = new_q;
   assign out_index_error         = index_error_q;
   assign out_bool_assignment     = bool_q;
   assign out_debug_state         = state_q;
   assign out_debug_lfsr          = lfsr_state;

endmodule

// File: tb/tb_variable_proposal_generator.sv
// Directed bench for variable_proposal_generator: hand-computed proposals from the known LFSR sequence.
module tb_variable_proposal_generator;
   import variable_proposal_generator_pkg::*;

   localparam int IW = BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_choice_valid = 1'b0;
   logic          in_boolean_or_integer = 1'b0;
   logic [IW-1:0] in_choosen_index = '0;
   logic          out_choice_ready;
   logic          in_init_we = 1'b0;
   logic          in_init_is_boolean = 1'b0;
   logic [IW-1:0] in_init_index = '0;
   logic [7:0]    in_init_value = '0;
   logic          out_proposal_valid;
   logic          out_proposal_is_boolean;
   logic [IW-1:0] out_proposal_index;
   logic [7:0]    out_old_value;
   logic [7:0]    out_new_value;
   logic          in_decision_valid = 1'b0;
   logic          in_accept = 1'b0;
   logic          out_index_error;
   logic [7:0]    out_bool_assignment;
   logic [1:0]    out_debug_state;
   logic [7:0]    out_debug_lfsr;

   int            n_vec = 0;
   int            n_bad = 0;
   logic [15:0]   exp_q[$];

   // Clock / reset
   always #5 clk = ~clk;

   variable_proposal_generator dut (
      .in_clock                (clk),
      .in_reset                (rst_n),
      .in_choice_valid         (in_choice_valid),
      .in_boolean_or_integer   (in_boolean_or_integer),
      .in_choosen_index        (in_choosen_index),
      .out_choice_ready        (out_choice_ready),
      .in_init_we              (in_init_we),
      .in_init_is_boolean      (in_init_is_boolean),
      .in_init_index           (in_init_index),
      .in_init_value           (in_init_value),
      .out_proposal_valid      (out_proposal_valid),
      .out_proposal_is_boolean (out_proposal_is_boolean),
      .out_proposal_index      (out_proposal_index),
      .out_old_value           (out_old_value),
      .out_new_value           (out_new_value),
      .in_decision_valid       (in_decision_valid),
      .in_accept               (in_accept),
      .out_index_error         (out_index_error),
      .out_bool_assignment     (out_bool_assignment),
      .out_debug_state         (out_debug_state),
      .out_debug_lfsr          (out_debug_lfsr)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Driver tasks
   task automatic init_write(input logic is_bool, input logic [IW-1:0] idx, input logic [7:0] val);
      in_init_we         = 1'b1;
      in_init_is_boolean = is_bool;
      in_init_index      = idx;
      in_init_value      = val;
      tick();
      in_init_we         = 1'b0;
   endtask

   task automatic choose(input logic is_bool, input logic [IW-1:0] idx);
      in_choice_valid       = 1'b1;
      in_boolean_or_integer = is_bool;
      in_choosen_index      = idx;
      tick();
      in_choice_valid       = 1'b0;
   endtask

   task automatic offer(input string tag, input logic is_bool, input logic [IW-1:0] idx);
      logic [15:0] e;
      choose(is_bool, idx);
      check_vec({tag, "_propose_valid"}, 32'(out_proposal_valid), 32'd0);
      check_vec({tag, "_propose_state"}, 32'(out_debug_state), 32'd1);
      tick();
      e = exp_q.pop_front();
      check_vec({tag, "_valid"}, 32'(out_proposal_valid), 32'd1);
      check_vec({tag, "_is_bool"}, 32'(out_proposal_is_boolean), 32'(is_bool));
      check_vec({tag, "_index"}, 32'(out_proposal_index), 32'(idx));
      check_vec({tag, "_old"}, 32'(out_old_value), 32'(e[15:8]));
      check_vec({tag, "_new"}, 32'(out_new_value), 32'(e[7:0]));
   endtask

   task automatic decide(input string tag, input logic acc);
      in_decision_valid = 1'b1;
      in_accept         = acc;
      tick();
      in_decision_valid = 1'b0;
      in_accept         = 1'b0;
      check_vec({tag, "_valid_drop"}, 32'(out_proposal_valid), 32'd0);
      check_vec({tag, "_state_idle"}, 32'(out_debug_state), 32'd0);
   endtask

   initial begin
      // Reset held
      repeat (2) tick();
      check_vec("rst_ready", 32'(out_choice_ready), 32'd0);
      check_vec("rst_valid", 32'(out_proposal_valid), 32'd0);
      check_vec("rst_bool", 32'(out_bool_assignment), 32'h00);
      check_vec("rst_lfsr", 32'(out_debug_lfsr), 32'h5A);
      check_vec("rst_state", 32'(out_debug_state), 32'd0);
      check_vec("rst_err", 32'(out_index_error), 32'd0);
      rst_n = 1'b1;
      #1;
      check_vec("rel_ready", 32'(out_choice_ready), 32'd1);
      tick();

      // int2=10, lfsr 2D: +2 -> 12, rejected
      init_write(1'b0, 4'd2, 8'd10);
      exp_q.push_back({8'h0A, 8'h0C});
      offer("int2_walk", 1'b0, 4'd2);
      decide("int2_reject", 1'b0);

      // bool3 flip with lfsr AE, held a cycle, then accepted
      exp_q.push_back({8'h00, 8'h01});
      offer("bool3_flip", 1'b1, 4'd3);
      tick();
      check_vec("bool3_hold_valid", 32'(out_proposal_valid), 32'd1);
      check_vec("bool3_hold_new", 32'(out_new_value), 32'h01);
      check_vec("bool3_hold_vec", 32'(out_bool_assignment), 32'h00);
      decide("bool3_accept", 1'b1);
      check_vec("bool3_commit", 32'(out_bool_assignment), 32'h08);

      // int1=125, lfsr 57: +4 -> 129 clamps to 127
      init_write(1'b0, 4'd1, 8'h7D);
      exp_q.push_back({8'h7D, 8'h7F});
      offer("int1_sat_hi", 1'b0, 4'd1);
      decide("int1_sat_hi_acc", 1'b1);

      // int1=-127, lfsr 93: -4 -> -131 clamps to -128
      init_write(1'b0, 4'd1, 8'h81);
      exp_q.push_back({8'h81, 8'h80});
      offer("int1_sat_lo", 1'b0, 4'd1);
      decide("int1_sat_lo_acc", 1'b1);

      // int2 still 10 after the reject; lfsr F1: -2 -> 8
      exp_q.push_back({8'h0A, 8'h08});
      offer("int2_after_reject", 1'b0, 4'd2);
      decide("int2_after_reject_rej", 1'b0);

      // int1 committed -128; lfsr C0: -1 clamps back to -128, still proposed
      exp_q.push_back({8'h80, 8'h80});
      offer("int1_clamp_same", 1'b0, 4'd1);
      decide("int1_clamp_same_rej", 1'b0);

      // Out-of-range bool index: pulse, no proposal, lfsr C0 -> 60
      choose(1'b1, 4'd8);
      check_vec("bool_oor_err", 32'(out_index_error), 32'd1);
      check_vec("bool_oor_valid", 32'(out_proposal_valid), 32'd0);
      check_vec("bool_oor_state", 32'(out_debug_state), 32'd0);
      check_vec("bool_oor_lfsr", 32'(out_debug_lfsr), 32'h60);
      tick();
      check_vec("bool_oor_pulse_end", 32'(out_index_error), 32'd0);

      // Out-of-range int index: lfsr 60 -> 30
      choose(1'b0, 4'd4);
      check_vec("int_oor_err", 32'(out_index_error), 32'd1);
      check_vec("int_oor_lfsr", 32'(out_debug_lfsr), 32'h30);
      tick();
      check_vec("int_oor_pulse_end", 32'(out_index_error), 32'd0);

      // Init write beats a simultaneous choice
      in_init_we            = 1'b1;
      in_init_is_boolean    = 1'b1;
      in_init_index         = 4'd5;
      in_init_value         = 8'h01;
      in_choice_valid       = 1'b1;
      in_boolean_or_integer = 1'b1;
      in_choosen_index      = 4'd0;
      #1;
      check_vec("prio_ready", 32'(out_choice_ready), 32'd0);
      tick();
      in_init_we      = 1'b0;
      in_choice_valid = 1'b0;
      check_vec("prio_init_applied", 32'(out_bool_assignment), 32'h28);
      check_vec("prio_state", 32'(out_debug_state), 32'd0);
      check_vec("prio_lfsr", 32'(out_debug_lfsr), 32'h30);

      // Reset while a proposal is on offer
      exp_q.push_back({8'h00, 8'h01});
      offer("bool0_flip", 1'b1, 4'd0);
      check_vec("bool0_lfsr", 32'(out_debug_lfsr), 32'h18);
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("midrst_valid", 32'(out_proposal_valid), 32'd0);
      check_vec("midrst_bool", 32'(out_bool_assignment), 32'h00);
      check_vec("midrst_lfsr", 32'(out_debug_lfsr), 32'h5A);
      check_vec("midrst_ready", 32'(out_choice_ready), 32'd0);
      in_decision_valid = 1'b1;
      in_accept         = 1'b1;
      #1;
      rst_n = 1'b1;
      tick();
      in_decision_valid = 1'b0;
      in_accept         = 1'b0;
      check_vec("late_decision_bool", 32'(out_bool_assignment), 32'h00);
      check_vec("late_decision_state", 32'(out_debug_state), 32'd0);
      check_vec("late_decision_valid", 32'(out_proposal_valid), 32'd0);

      // Integers cleared and lfsr reseeded: int2 0 -> +2
      exp_q.push_back({8'h00, 8'h02});
      offer("int2_after_reset", 1'b0, 4'd2);
      decide("int2_after_reset_acc", 1'b1);

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
